sprite_index_fetch: RTL and testbench

//  Pixel-side producer of the 2-bit palette index that the colour LUT turns into RGB.

---
 rtl/sprite_index_fetch_if.sv | 30 +++
 rtl/sprite_index_fetch.sv | 81 ++++++++
 tb/tb_sprite_index_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_index_fetch_if.sv
// Pixel request, sprite ROM and palette-index output signals of sprite_index_fetch.
interface sprite_index_fetch_if #(
   parameter int unsigned ROM_AW = 11
);
   logic              req_valid;
   logic              req_ready;
   logic [9:0]        draw_x;
   logic [9:0]        draw_y;
   logic [9:0]        spr_x;
   logic [9:0]        spr_y;
   logic [3:0]        spr_sel;
   logic              rom_en;
   logic [ROM_AW-1:0] rom_addr;
   logic [1:0]        rom_data;
   logic              pix_valid;
   logic              pix_ready;
   logic [1:0]        pix_index;
   logic              pix_hit;
   logic [15:0]       hit_count;

   modport slave (
      input  req_valid, draw_x, draw_y, spr_x, spr_y, spr_sel, rom_data, pix_ready,
      output req_ready, rom_en, rom_addr, pix_valid, pix_index, pix_hit, hit_count
   );

   modport master (
      output req_valid, draw_x, draw_y, spr_x, spr_y, spr_sel, rom_data, pix_ready,
      input  req_ready, rom_en, rom_addr, pix_valid, pix_index, pix_hit, hit_count
   );
endinterface

// File: rtl/sprite_index_fetch.sv
// Sprite hit test plus bitmap ROM fetch; returns one 2-bit palette index per pixel request.
module sprite_index_fetch #(
   parameter int unsigned SPR_W      = 16,
   parameter int unsigned SPR_H      = 8,
   parameter int unsigned NUM_SPR    = 16,
   parameter int unsigned SCALE_LOG2 = 1,
   parameter int unsigned ROM_AW     = 11
) (
   input logic                 Clk,
   input logic                 Reset,
   sprite_index_fetch_if.slave bus
);
   localparam int unsigned CW = 11;
   localparam logic [CW-1:0] X_LIM = CW'(SPR_W << SCALE_LOG2);
   localparam logic [CW-1:0] Y_LIM = CW'(SPR_H << SCALE_LOG2);
   localparam logic [1:0] IDX_BG = 2'd1;

   logic [CW-1:0] dx;
   logic [CW-1:0] dy;
   logic          x_in;
   logic          y_in;
   logic          sel_ok;
   logic          hit;
   logic [31:0]   addr_full;
   logic          advance;
   logic          s1_valid;
   logic          s1_hit;

   // Offsets inside the sprite, hit decision and bitmap address for the current request
   always_comb begin
      dx        = {1'b0, bus.draw_x} - {1'b0, bus.spr_x};
      dy        = {1'b0, bus.draw_y} - {1'b0, bus.spr_y};
      x_in      = (bus.draw_x >= bus.spr_x) && (dx < X_LIM);
      y_in      = (bus.draw_y >= bus.spr_y) && (dy < Y_LIM);
      sel_ok    = 32'(bus.spr_sel) < NUM_SPR;
      hit       = x_in && y_in && sel_ok;
      addr_full = 32'(bus.spr_sel) * SPR_W * SPR_H
                + 32'(dy >> SCALE_LOG2) * SPR_W
                + 32'(dx >> SCALE_LOG2);
   end

   // Whole pipe moves together; a stalled output freezes the ROM too so its data is kept
   assign advance       = !bus.pix_valid || bus.pix_ready;
   assign bus.req_ready = advance;
   assign bus.rom_en    = advance;
   assign bus.rom_addr  = hit ? ROM_AW'(addr_full) : '0;

   // S1: tracks the beat whose ROM read is in flight
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid <= 1'b0;
         s1_hit   <= 1'b0;
      end else if (advance) begin
         s1_valid <= bus.req_valid;
         s1_hit   <= bus.req_valid && hit;
      end
   end

   // S2: output beat; misses become background regardless of ROM contents
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.pix_valid <= 1'b0;
         bus.pix_index <= IDX_BG;
         bus.pix_hit   <= 1'b0;
      end else if (advance) begin
         bus.pix_valid <= s1_valid;
         bus.pix_hit   <= s1_valid && s1_hit;
         bus.pix_index <= (s1_valid && s1_hit) ? bus.rom_data : IDX_BG;
      end
   end

   // Delivered sprite-pixel counter, saturating
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.hit_count <= 16'd0;
      end else if (bus.pix_valid && bus.pix_ready && bus.pix_hit
                   && (bus.hit_count != 16'hFFFF)) begin
         bus.hit_count <= bus.hit_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_sprite_index_fetch.sv
// Directed bench for sprite_index_fetch: hit/miss math, ROM addressing, stalls, reset, saturation.
module tb_sprite_index_fetch;
   logic Clk;
   logic Reset;

   sprite_index_fetch_if #(.ROM_AW(11)) bus ();

   sprite_index_fetch #(
      .SPR_W(16), .SPR_H(8), .NUM_SPR(8), .SCALE_LOG2(1), .ROM_AW(11)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Synchronous ROM image: texel = a[1:0] ^ a[9:8] ^ 2'b10
   function automatic logic [1:0] rom_fn(input logic [10:0] a);
      return a[1:0] ^ a[9:8] ^ 2'b10;
   endfunction

   always @(posedge Clk) begin
      if (bus.rom_en) bus.rom_data <= rom_fn(bus.rom_addr);
   end

   typedef struct {
      logic [9:0]  x, y, sx, sy;
      logic [3:0]  sel;
      logic [10:0] addr;
      logic        hit;
      logic [1:0]  idx;
   } vec_t;

   vec_t pend[$];
   vec_t exp_q[$];
   int   acc_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   model_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic add_vec(input int x, input int y, input int sel,
                          input int addr, input bit hit, input int idx);
      vec_t v;
      v.x = 10'(x); v.y = 10'(y); v.sx = 10'd100; v.sy = 10'd50;
      v.sel = 4'(sel); v.addr = 11'(addr); v.hit = hit; v.idx = 2'(idx);
      pend.push_back(v);
   endtask

   // Streams pend through the DUT, pix_ready low for cycles stall_lo..stall_hi
   task automatic run_vecs(input int stall_lo, input int stall_hi, input bit chk_lat);
      int cyc = 0;
      int pi  = 0;
      vec_t e;
      int   a;
      while ((pi < pend.size() || exp_q.size() > 0) && cyc < 200) begin
         @(negedge Clk);
         bus.pix_ready = !(cyc >= stall_lo && cyc <= stall_hi);
         if (pi < pend.size()) begin
            bus.req_valid = 1'b1;
            bus.draw_x = pend[pi].x;  bus.draw_y = pend[pi].y;
            bus.spr_x  = pend[pi].sx; bus.spr_y  = pend[pi].sy;
            bus.spr_sel = pend[pi].sel;
         end else begin
            bus.req_valid = 1'b0;
         end
         #1;
         if (bus.pix_valid && !bus.pix_ready) begin
            chk("stall_req_ready", 32'(bus.req_ready), 0);
            chk("stall_rom_en", 32'(bus.rom_en), 0);
            if (exp_q.size() > 0) chk("stall_hold_idx", 32'(bus.pix_index), 32'(exp_q[0].idx));
         end
         if (bus.req_valid && bus.req_ready) begin
            chk("rom_addr", 32'(bus.rom_addr), 32'(pend[pi].addr));
            chk("rom_en", 32'(bus.rom_en), 1);
            exp_q.push_back(pend[pi]);
            acc_q.push_back(cyc);
            pi++;
         end
         if (bus.pix_valid && bus.pix_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk("pix_hit", 32'(bus.pix_hit), 32'(e.hit));
               chk("pix_index", 32'(bus.pix_index), 32'(e.idx));
               if (chk_lat) chk("latency", 32'(cyc - a), 2);
               if (e.hit && model_cnt < 65535) model_cnt++;
            end
         end
         cyc++;
      end
      chk("leftover", 32'(exp_q.size() + pend.size() - pi), 0);
      exp_q.delete();
      acc_q.delete();
      pend.delete();
      @(negedge Clk);
      bus.req_valid = 1'b0;
      #1;
      chk("drained", 32'(bus.pix_valid), 0);
      chk("hit_count", 32'(bus.hit_count), 32'(model_cnt));
   endtask

   initial begin
      int acc;
      int got;
      Reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.pix_ready = 1'b0;
      bus.draw_x = '0; bus.draw_y = '0; bus.spr_x = '0; bus.spr_y = '0; bus.spr_sel = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_pix_valid", 32'(bus.pix_valid), 0);
      chk("rst_pix_index", 32'(bus.pix_index), 1);
      chk("rst_pix_hit", 32'(bus.pix_hit), 0);
      chk("rst_hit_count", 32'(bus.hit_count), 0);
      Reset = 1'b0;

      // Sprite top-left texel
      add_vec(100, 50, 2, 256, 1, 3);
      run_vecs(-1, -1, 1'b1);

      // Far corner texel and the misses just outside each edge
      add_vec(131, 65, 2, 383, 1, 0);
      add_vec(132, 50, 2, 0, 0, 1);
      add_vec( 99, 50, 2, 0, 0, 1);
      add_vec(100, 66, 2, 0, 0, 1);
      add_vec(100, 49, 2, 0, 0, 1);
      run_vecs(-1, -1, 1'b1);

      // Bitmap select range with NUM_SPR=8
      add_vec(100, 50, 15, 0, 0, 1);
      add_vec(100, 50, 8, 0, 0, 1);
      add_vec(100, 50, 7, 896, 1, 1);
      run_vecs(-1, -1, 1'b1);
      chk("cnt_after_sel", 32'(bus.hit_count), 3);

      // Back-to-back hits along the diagonal with a 3-cycle output stall
      add_vec(100, 50, 2, 256, 1, 3);
      add_vec(102, 52, 2, 273, 1, 2);
      add_vec(104, 54, 2, 290, 1, 1);
      add_vec(106, 56, 2, 307, 1, 0);
      add_vec(108, 58, 2, 324, 1, 3);
      add_vec(110, 60, 2, 341, 1, 2);
      add_vec(112, 62, 2, 358, 1, 1);
      add_vec(114, 64, 2, 375, 1, 0);
      run_vecs(3, 5, 1'b0);
      chk("cnt_after_stream", 32'(bus.hit_count), 11);

      // Reset one cycle after two accepts
      @(negedge Clk);
      bus.draw_x = 10'd100; bus.draw_y = 10'd50; bus.spr_x = 10'd100; bus.spr_y = 10'd50;
      bus.spr_sel = 4'd2; bus.req_valid = 1'b1; bus.pix_ready = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      bus.req_valid = 1'b0;
      Reset = 1'b1;
      #1;
      chk("pre_rst_valid", 32'(bus.pix_valid), 1);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk("post_rst_valid", 32'(bus.pix_valid), 0);
      chk("post_rst_count", 32'(bus.hit_count), 0);
      chk("post_rst_hit", 32'(bus.pix_hit), 0);
      @(negedge Clk);
      #1;
      chk("post_rst_valid2", 32'(bus.pix_valid), 0);
      model_cnt = 0;

      // Long run of hits up to one below saturation
      acc = 0;
      got = 0;
      for (int c = 0; c < 70000 && got < 65534; c++) begin
         @(negedge Clk);
         bus.pix_ready = 1'b1;
         bus.req_valid = (acc < 65534);
         #1;
         if (bus.req_valid && bus.req_ready) acc++;
         if (bus.pix_valid && bus.pix_ready && bus.pix_hit) got++;
      end
      @(negedge Clk);
      bus.req_valid = 1'b0;
      #1;
      chk("long_run_beats", 32'(got), 65534);
      chk("cnt_fffe", 32'(bus.hit_count), 32'hFFFE);
      model_cnt = 65534;

      add_vec(100, 50, 2, 256, 1, 3);
      add_vec(102, 52, 2, 273, 1, 2);
      run_vecs(-1, -1, 1'b1);
      chk("cnt_sat", 32'(bus.hit_count), 32'hFFFF);
      add_vec(104, 54, 2, 290, 1, 1);
      run_vecs(-1, -1, 1'b1);
      chk("cnt_sat_hold", 32'(bus.hit_count), 32'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
